// File: rtl/rot_step_sequencer_if.sv
// Request/result bundle for rot_step_sequencer: a byte, rotate amount and direction
// in, the rotated byte out, each on its own valid/ready pair.
interface rot_step_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_lr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amt, in_lr, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_lr, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/rot_step_sequencer.sv
// Multi-step rotator: accepts a byte and an amount, rotates it by one bit per clock,
// then holds the result on a valid/ready output until it is taken.
module rot_step_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rot_step_sequencer_if.slave  bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic             r_lr;
  logic [WIDTH-1:0] w_rot;
  logic             w_accept;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the result is held unchanged while
  // out_valid is high and out_ready is low.
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_data  = r_data;
  assign o_dbg_state   = r_state;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);

  // Single-step rotator: lr=1 rotates right by one, lr=0 rotates left by one.
  assign w_rot = r_lr ? {r_data[0], r_data[WIDTH-1:1]}
                      : {r_data[WIDTH-2:0], r_data[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_lr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= bus.in_data;
            r_cnt   <= bus.in_amt;
            r_lr    <= bus.in_lr;
            r_state <= (bus.in_amt == '0) ? ST_DONE : ST_ROT;
          end
        end
        ST_ROT: begin
          // Entered only with r_cnt >= 1, so the decrement cannot wrap.
          r_data <= w_rot;
          r_cnt  <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
